// File: rtl/uart_bus_master.sv
// Executes decoded UART command words on a single-master Wishbone-classic style bus.
// Returns exactly one response word per command, in command arrival order.
module uart_bus_master #(
    parameter int AW         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic          i_clk,
    input  logic          rst,
    input  logic          i_stb,
    input  logic [33:0]   i_word,
    output logic          o_bus_cyc,
    output logic          o_bus_stb,
    output logic          o_bus_we,
    output logic [AW-1:0] o_bus_addr,
    output logic [31:0]   o_bus_data,
    input  logic          i_bus_ack,
    input  logic          i_bus_err,
    input  logic [31:0]   i_bus_data,
    output logic          o_rsp_stb,
    output logic [33:0]   o_rsp_word,
    input  logic          i_rsp_busy,
    output logic          o_overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] CMD_R = 2'b00;
    localparam logic [1:0] CMD_W = 2'b01;
    localparam logic [1:0] CMD_A = 2'b10;
    localparam logic [1:0] CMD_S = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        BUS  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Command queue
    logic [33:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full, empty, pop, push, drop;
    logic [33:0]   head;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign head  = fifo_mem[rd_ptr_q];
    // A full queue still accepts a word when the head leaves on the same edge.
    assign push  = i_stb && (!full || pop);
    assign drop  = i_stb && full && !pop;

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= i_word;
        end
    end

    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sequencer registers
    logic [1:0]    cmd_q, cmd_d;
    logic [31:0]   payload_q, payload_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          autoinc_q, autoinc_d;
    logic          overflow_q, overflow_d;
    logic          ovf_clr;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [31:0]   bus_data_q, bus_data_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          rsp_stb_q, rsp_stb_d;
    logic [33:0]   rsp_word_q, rsp_word_d;
    logic          bus_done;

    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cmd_q      <= CMD_R;
            payload_q  <= '0;
            addr_q     <= '0;
            autoinc_q  <= 1'b1;
            overflow_q <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            cnt_q      <= '0;
            rsp_stb_q  <= 1'b0;
            rsp_word_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            payload_q  <= payload_d;
            addr_q     <= addr_d;
            autoinc_q  <= autoinc_d;
            overflow_q <= overflow_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            cnt_q      <= cnt_d;
            rsp_stb_q  <= rsp_stb_d;
            rsp_word_q <= rsp_word_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        cmd_d      = cmd_q;
        payload_d  = payload_q;
        addr_d     = addr_q;
        autoinc_d  = autoinc_q;
        ovf_clr    = 1'b0;
        cyc_d      = cyc_q;
        we_d       = we_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        cnt_d      = cnt_q;
        rsp_stb_d  = rsp_stb_q;
        rsp_word_d = rsp_word_q;
        bus_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    cmd_d     = head[33:32];
                    payload_d = head[31:0];
                    state_d   = EXEC;
                end
            end

            EXEC: begin
                case (cmd_q)
                    CMD_A: begin
                        addr_d     = payload_q[AW-1:0];
                        rsp_word_d = {2'b10, payload_q};
                        rsp_stb_d  = 1'b1;
                        state_d    = RESP;
                    end
                    CMD_S: begin
                        autoinc_d  = payload_q[0];
                        ovf_clr    = payload_q[1];
                        // Status reports overflow as it was before this command cleared it.
                        rsp_word_d = {2'b10, overflow_q, payload_q[0], 30'b0};
                        rsp_stb_d  = 1'b1;
                        state_d    = RESP;
                    end
                    default: begin
                        cyc_d      = 1'b1;
                        we_d       = (cmd_q == CMD_W);
                        bus_addr_d = addr_q;
                        bus_data_d = payload_q;
                        cnt_d      = TW'(TIMEOUT);
                        state_d    = BUS;
                    end
                endcase
            end

            BUS: begin
                cnt_d = cnt_q - TW'(1);
                if (i_bus_err) begin
                    rsp_word_d = {2'b11, 32'h0000_0001};
                    bus_done   = 1'b1;
                end else if (i_bus_ack) begin
                    rsp_word_d = (cmd_q == CMD_R) ? {2'b00, i_bus_data} : {2'b01, payload_q};
                    if (autoinc_q) begin
                        addr_d = addr_q + AW'(1);
                    end
                    bus_done = 1'b1;
                end else if (cnt_q == TW'(1)) begin
                    rsp_word_d = {2'b11, 32'h0000_0002};
                    bus_done   = 1'b1;
                end
                if (bus_done) begin
                    cyc_d     = 1'b0;
                    rsp_stb_d = 1'b1;
                    state_d   = RESP;
                end
            end

            RESP: begin
                if (!i_rsp_busy) begin
                    rsp_stb_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // A fresh drop outranks a clear issued on the same edge.
        overflow_d = (overflow_q && !ovf_clr) || drop;
    end

    assign o_bus_cyc  = cyc_q;
    assign o_bus_stb  = cyc_q;
    assign o_bus_we   = we_q;
    assign o_bus_addr = bus_addr_q;
    assign o_bus_data = bus_data_q;
    assign o_rsp_stb  = rsp_stb_q;
    assign o_rsp_word = rsp_word_q;
    assign o_overflow = overflow_q;

endmodule
